serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Serial-to-parallel word receiver: accepts a framed, MSB-first bit stream one bit per strobe and assembles it into a WIDTH-bit word, presented on a valid/ready output with one word of holding buffer. It is the receiving end of the serial path whose transmit side is a parallel-load universal shift register shifting words out one bit per clock. It sits between that serial link and the word-level consumer (register file, backplane bus interface).

## Interface
- WIDTH, 36: word length in bits; legal range 2..64.
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- SIN  in  1  serial data bit; sampled only when SVALID=1.
- SVALID  in  1  bit strobe; one bit is taken per CLK edge on which SVALID=1.
- SFRAME  in  1  start-of-word marker; qualified by SVALID and marks SIN as the first bit of a word.
- WORD  out  [0:WIDTH-1]  assembled word; WORD[0] holds the first bit received.
- WVALID  out  1  WORD holds an unconsumed word.
- WREADY  in  1  consumer accepts WORD on an edge where WVALID=1 and WREADY=1.
- BUSY  out  1  a partial word is being assembled.
- FERR  out  1  one-cycle pulse for a framing error.
- OVR  out  1  sticky overrun flag.
- CLROVR  in  1  clears OVR.

## Operation
- Internal state: a WIDTH-bit shift register SH, a bit counter CNT of $clog2(WIDTH+1) bits, a holding register driving WORD/WVALID, and a 2-state FSM (IDLE, SHIFT). BUSY is high exactly when the FSM is in SHIFT.
- Shifting: SH <= {SH[1:WIDTH-1], SIN}, so after WIDTH shifts the first bit is at SH[0].
- IDLE:
  - SVALID=1 with SFRAME=0: the bit is ignored and no error is flagged.
  - SVALID=1 with SFRAME=1: shift SIN into SH, set CNT=1, go to SHIFT.
- SHIFT:
  - SVALID=0: hold state.
  - SVALID=1 with SFRAME=0: shift and increment CNT.
  - When that bit is the WIDTH-th (CNT=WIDTH-1 before the edge), the word completes. The completed value {SH[1:WIDTH-1], SIN} goes to the holding logic, CNT is set to 0 and the FSM goes to IDLE.
  - SVALID=1 with SFRAME=1: framing error. Pulse FERR for one cycle, discard the partial word, treat SIN as the first bit of a new word (CNT=1) and stay in SHIFT.
- Holding logic on word completion:
  - Holding register empty, or drained on the same edge (WVALID and WREADY): load WORD and set WVALID=1.
  - Otherwise: the new word is dropped, WORD and WVALID are unchanged, and OVR is set.
- Output handshake:
  - WVALID clears on an edge with WVALID and WREADY, unless a new word loads on the same edge, in which case it stays high with the new WORD.
  - WORD is stable while WVALID=1 and WREADY=0.
- Flags:
  - OVR stays set until an edge with CLROVR=1.
  - If CLROVR and a new overrun occur on the same edge, the overrun wins and OVR remains 1.
  - FERR is low on every cycle with no framing error.
- Values of X on SIN are don't-care when SVALID=0.

## Timing
- Reset (asynchronous, takes effect immediately): FSM=IDLE, CNT=0, SH=0, WORD=0, WVALID=0, BUSY=0, FERR=0, OVR=0.
  - Reset in mid-word discards the partial word.
  - Reset while WVALID=1 discards the held word.
  - Reception restarts only at the next SFRAME after RESET deasserts.
- Latency: the last bit is sampled at edge N. WVALID=1 and WORD are valid after edge N, and a consumer can accept at edge N+1.
- Throughput: back-to-back words with no idle cycles are supported. An SFRAME bit on the edge after completion starts the next word. With WREADY held high, no overrun occurs at full rate.
- FERR is asserted for exactly the cycle following the offending edge.
- BUSY rises after the SFRAME edge and falls after the completing edge.
- No combinational path from any input to any output.

## Test plan
- WIDTH=36. Send SFRAME plus 36 bits of 0o123456701234 MSB-first, with WREADY=1 -> WVALID=1 for one cycle after the 36th bit edge, WORD=0o123456701234, OVR=0, FERR=0.
- Gapped strobes: same word with SVALID low on random cycles -> identical WORD, and BUSY stays high throughout the gaps.
- WREADY=0. Send two complete words A then B -> WORD=A held, WVALID=1, OVR=1 after B completes. Then CLROVR=1 for one cycle -> OVR=0 and WORD still A.
- After 10 bits of a word, assert SFRAME with a new word -> FERR pulses once. The resulting WORD equals the second word only, with 36 bits counted from the SFRAME bit.
- Completion on the same edge as a WVALID&WREADY accept -> WVALID stays 1, WORD switches to the new word, OVR=0. Stray SVALID bits while IDLE without SFRAME -> no state change.
- Assert RESET asynchronously mid-word (bit 20) and again with WVALID=1 -> all outputs 0 immediately. A subsequent full word is received correctly.

Source files
------------

// File: rtl/serial_word_rx.sv
// serial_word_rx: frames an MSB-first serial bit stream into WIDTH-bit words.
// The first bit received lands in word_o[0]. One completed word can wait in
// the holding register until the consumer takes it.
//
// Handshake: a word moves to the consumer on a clk_i edge where wvalid_o=1
// and wready_i=1. wvalid_o only drops on such an edge, unless a new word
// loads on that same edge. word_o does not change while wvalid_o=1 and
// wready_i=0.
//
// All outputs come straight from registers, so no input reaches an output
// combinationally.
module serial_word_rx #(
    parameter int WIDTH = 36
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sin_i,
    input  logic             svalid_i,
    input  logic             sframe_i,
    output logic [0:WIDTH-1] word_o,
    output logic             wvalid_o,
    input  logic             wready_i,
    output logic             busy_o,
    output logic             ferr_o,
    output logic             ovr_o,
    input  logic             clrovr_i
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [0:WIDTH-1] sh_q;
    logic [0:WIDTH-1] sh_d;
    logic [0:WIDTH-1] word_q;
    logic             wvalid_q;
    logic             ferr_q;
    logic             ovr_q;

    logic             word_done;
    logic             drain;
    logic             load;
    logic             overrun;

    // Shifted value and completion / holding-register decisions for this edge.
    always_comb begin
        sh_d      = {sh_q[1:WIDTH-1], sin_i};
        word_done = (state_q == SHIFT) && svalid_i && !sframe_i && (cnt_q == LAST_CNT);
        drain     = wvalid_q && wready_i;
        // A completing word fits if the holder is empty or being drained now.
        load      = word_done && (!wvalid_q || wready_i);
        overrun   = word_done && !load;
    end

    // Framing FSM, shift register, holding register and flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ferr_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Bits without a frame marker are ignored silently.
                    if (svalid_i && sframe_i) begin
                        sh_q    <= sh_d;
                        cnt_q   <= CNT_W'(1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (svalid_i) begin
                        sh_q <= sh_d;
                        if (sframe_i) begin
                            // Early frame marker: drop the partial word and
                            // restart counting from this bit.
                            ferr_q <= 1'b1;
                            cnt_q  <= CNT_W'(1);
                        end else if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load) begin
                word_q   <= sh_d;
                wvalid_q <= 1'b1;
            end else if (drain) begin
                wvalid_q <= 1'b0;
            end

            // A fresh overrun takes priority over a clear on the same edge.
            if (overrun) begin
                ovr_q <= 1'b1;
            end else if (clrovr_i) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign word_o   = word_q;
    assign wvalid_o = wvalid_q;
    assign busy_o   = (state_q == SHIFT);
    assign ferr_o   = ferr_q;
    assign ovr_o    = ovr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx. The driver sends words MSB-first and pushes the
// expected word into exp_q. A monitor pops exp_q on each accepted output word
// and compares.
module tb_serial_word_rx;

    localparam int W = 36;

    localparam logic [W-1:0] WORD_A = 36'o123456701234;
    localparam logic [W-1:0] WORD_B = 36'o765432107654;
    localparam logic [W-1:0] WORD_C = 36'o000777000777;
    localparam logic [W-1:0] WORD_D = 36'o525252525252;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         reset;
    logic         sin;
    logic         svalid;
    logic         sframe;
    logic [0:W-1] word_o;
    logic         wvalid_o;
    logic         wready;
    logic         busy_o;
    logic         ferr_o;
    logic         ovr_o;
    logic         clrovr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_word_rx #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .sin_i    (sin),
        .svalid_i (svalid),
        .sframe_i (sframe),
        .word_o   (word_o),
        .wvalid_o (wvalid_o),
        .wready_i (wready),
        .busy_o   (busy_o),
        .ferr_o   (ferr_o),
        .ovr_o    (ovr_o),
        .clrovr_i (clrovr)
    );

    // ---------------- scoreboard ----------------
    int           tests = 0;
    int           fails = 0;
    int           ferr_cnt = 0;
    int           ferr_base;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the word is taken on the next posedge when valid and ready are high.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (ferr_o) ferr_cnt++;
        if (!reset && wvalid_o && wready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL word_unexpected: got %0o expected none", word_o);
            end else begin
                e = exp_q.pop_front();
                check("word", 64'(word_o), 64'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Send bits first..first+count-1 of w (bit 0 is the MSB). On return the
    // last bit has just been clocked and svalid is still 1.
    task automatic send_bits(input logic [W-1:0] w, input int first, input int count,
                             input bit frame, input bit gaps);
        for (int i = first; i < first + count; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                svalid = 1'b0;
                sframe = 1'b0;
                sin    = 1'($urandom);
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    if (i > 0) check("busy_gap", 64'(busy_o), 64'd1);
                    @(posedge clk);
                    #1;
                end
            end
            sin    = w[W-1-i];
            sframe = frame && (i == first);
            svalid = 1'b1;
            @(posedge clk);
            #1;
        end
        sframe = 1'b0;
    endtask

    task automatic idle(input int n);
        svalid = 1'b0;
        sframe = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset  = 1'b1;
        sin    = 1'b0;
        svalid = 1'b0;
        sframe = 1'b0;
        wready = 1'b1;
        clrovr = 1'b0;
        #13;
        check("rst_wvalid", 64'(wvalid_o), 64'd0);
        check("rst_word", 64'(word_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ferr", 64'(ferr_o), 64'd0);
        check("rst_ovr", 64'(ovr_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word with the consumer always ready.
        exp_q.push_back(WORD_A);
        send_bits(WORD_A, 0, 18, 1'b1, 1'b0);
        @(negedge clk);
        check("busy_mid", 64'(busy_o), 64'd1);
        send_bits(WORD_A, 18, W - 18, 1'b0, 1'b0);
        svalid = 1'b0;
        @(negedge clk);
        check("done_wvalid", 64'(wvalid_o), 64'd1);
        check("done_word", 64'(word_o), 64'(WORD_A));
        check("done_busy", 64'(busy_o), 64'd0);
        check("done_ferr", 64'(ferr_o), 64'd0);
        check("done_ovr", 64'(ovr_o), 64'd0);
        @(negedge clk);
        check("wvalid_one_cycle", 64'(wvalid_o), 64'd0);
        @(posedge clk);
        #1;

        // Gapped strobes.
        exp_q.push_back(WORD_A);
        send_bits(WORD_A, 0, W, 1'b1, 1'b1);
        idle(3);

        // Back-to-back words at full rate.
        exp_q.push_back(WORD_B);
        exp_q.push_back(WORD_C);
        send_bits(WORD_B, 0, W, 1'b1, 1'b0);
        send_bits(WORD_C, 0, W, 1'b1, 1'b0);
        svalid = 1'b0;
        @(negedge clk);
        check("b2b_ovr", 64'(ovr_o), 64'd0);
        idle(2);

        // Overrun: consumer stalled, A held, B dropped.
        wready = 1'b0;
        exp_q.push_back(WORD_A);
        send_bits(WORD_A, 0, W, 1'b1, 1'b0);
        send_bits(WORD_B, 0, W, 1'b1, 1'b0);
        svalid = 1'b0;
        @(negedge clk);
        check("ovr_wvalid", 64'(wvalid_o), 64'd1);
        check("ovr_word", 64'(word_o), 64'(WORD_A));
        check("ovr_set", 64'(ovr_o), 64'd1);
        @(posedge clk);
        #1;
        clrovr = 1'b1;
        @(posedge clk);
        #1;
        clrovr = 1'b0;
        @(negedge clk);
        check("ovr_clear", 64'(ovr_o), 64'd0);
        check("ovr_word_kept", 64'(word_o), 64'(WORD_A));
        @(posedge clk);
        #1;
        wready = 1'b1;
        idle(2);

        // Framing error after 10 bits.
        ferr_base = ferr_cnt;
        exp_q.push_back(WORD_C);
        send_bits(WORD_B, 0, 10, 1'b1, 1'b0);
        send_bits(WORD_C, 0, 1, 1'b1, 1'b0);
        @(negedge clk);
        check("ferr_pulse", 64'(ferr_o), 64'd1);
        check("ferr_busy", 64'(busy_o), 64'd1);
        send_bits(WORD_C, 1, W - 1, 1'b0, 1'b0);
        svalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ferr_count", 64'(ferr_cnt - ferr_base), 64'd1);
        @(posedge clk);
        #1;

        // Completion on the same edge as an accept.
        wready = 1'b0;
        exp_q.push_back(WORD_A);
        exp_q.push_back(WORD_B);
        send_bits(WORD_A, 0, W, 1'b1, 1'b0);
        send_bits(WORD_B, 0, W - 1, 1'b1, 1'b0);
        wready = 1'b1;
        send_bits(WORD_B, W - 1, 1, 1'b0, 1'b0);
        svalid = 1'b0;
        @(negedge clk);
        check("same_edge_wvalid", 64'(wvalid_o), 64'd1);
        check("same_edge_word", 64'(word_o), 64'(WORD_B));
        check("same_edge_ovr", 64'(ovr_o), 64'd0);
        @(posedge clk);
        #1;

        // Stray bits while idle.
        for (int i = 0; i < 5; i++) begin
            sin    = 1'($urandom);
            svalid = 1'b1;
            sframe = 1'b0;
            @(posedge clk);
            #1;
        end
        svalid = 1'b0;
        @(negedge clk);
        check("stray_busy", 64'(busy_o), 64'd0);
        check("stray_wvalid", 64'(wvalid_o), 64'd0);
        check("stray_ferr", 64'(ferr_o), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-word.
        send_bits(WORD_C, 0, 20, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_wvalid", 64'(wvalid_o), 64'd0);
        svalid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset with a word held.
        wready = 1'b0;
        send_bits(WORD_D, 0, W, 1'b1, 1'b0);
        svalid = 1'b0;
        @(negedge clk);
        check("held_before_rst", 64'(word_o), 64'(WORD_D));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_held_wvalid", 64'(wvalid_o), 64'd0);
        check("arst_held_word", 64'(word_o), 64'd0);
        check("arst_held_ovr", 64'(ovr_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        wready = 1'b1;
        exp_q.push_back(WORD_C);
        send_bits(WORD_C, 0, W, 1'b1, 1'b0);
        idle(3);

        // Drain with a bounded wait.
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
